// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM states, fetch defaults and the bubble encoding.
// The FETCH_FAULT state only exists when IM_FAULT_EN is defined.
package cpu_pkg;

    localparam logic [31:0] DEFAULT_RESET_PC  = 32'h0000_3000;
    localparam logic [31:0] DEFAULT_HALT_WORD = 32'h0000_000C;
    localparam logic [31:0] NOP_INSTR         = 32'h0000_0000;
    localparam logic [32:0] IM_WINDOW_BYTES   = 33'd4096;

    typedef enum logic [1:0] {
        FETCH_BOOT  = 2'd0,
        FETCH_RUN   = 2'd1,
        FETCH_HALT  = 2'd2
`ifdef IM_FAULT_EN
        , FETCH_FAULT = 2'd3
`endif
    } fetch_state_e;

    // A redirect target is legal only if word-aligned and inside the 4 KiB image at base.
    function automatic logic redirect_illegal(input logic [31:0] target,
                                              input logic [31:0] base);
        logic [32:0] limit;
        limit = {1'b0, base} + IM_WINDOW_BYTES;
        return (target[1:0] != 2'b00) || (target < base) || ({1'b0, target} >= limit);
    endfunction

endpackage

// File: rtl/im_fetch_ctrl_if_id_reg.sv
// IF/ID pipeline register: clear (bubble) beats hold (stall), otherwise capture.
// Synchronous active-low reset loads a bubble.
module if_id_reg
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        hold_i,
    input  logic        clear_i,
    input  logic [31:0] instr_i,
    input  logic [31:0] pc4_i,
    output logic [31:0] instr_o,
    output logic [31:0] pc4_o,
    output logic        valid_o
);

    logic [31:0] instr_q;
    logic [31:0] pc4_q;
    logic        valid_q;

    // NOTE: non-blocking assignments in clocked logic so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n || clear_i) begin
            instr_q <= NOP_INSTR;
            pc4_q   <= 32'h0;
            valid_q <= 1'b0;
        end else if (!hold_i) begin
            instr_q <= instr_i;
            pc4_q   <= pc4_i;
            valid_q <= 1'b1;
        end
    end

    assign instr_o = instr_q;
    assign pc4_o   = pc4_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/im_fetch_ctrl.sv
// Instruction-fetch controller: PC, fetch FSM, fetch counter and IF/ID register.
// Define IM_FAULT_EN to trap illegal redirect targets in a sticky FAULT state.
module im_fetch_ctrl
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
    parameter logic [31:0] HALT_WORD = DEFAULT_HALT_WORD
)(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [9:0]  im_addr,
    input  logic [31:0] im_dout,
    output logic [31:0] pc,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_pc4,
    output logic        ifid_valid,
    output logic        halted,
    output logic        fault,
    output logic [31:0] fetch_count
);

    fetch_state_e state_q;
    logic [31:0]  pc_q;
    logic [31:0]  count_q;
    logic [31:0]  pc_plus4;
    logic         ifid_hold;
    logic         ifid_clear;

    assign pc_plus4 = pc_q + 32'd4;

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        ifid_hold  = 1'b1;
        ifid_clear = 1'b0;
        case (state_q)
            FETCH_BOOT: ifid_clear = 1'b1;
            FETCH_RUN: begin
                if (redirect)    ifid_clear = 1'b1;
                else if (!stall) ifid_hold  = 1'b0;
            end
            FETCH_HALT: ifid_clear = redirect || !stall;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= FETCH_BOOT;
            pc_q    <= RESET_PC;
            count_q <= 32'h0;
        end else begin
            case (state_q)
                FETCH_BOOT: state_q <= FETCH_RUN;
                FETCH_RUN, FETCH_HALT: begin
                    if (redirect) begin
`ifdef IM_FAULT_EN
                        if (redirect_illegal(redirect_pc, RESET_PC)) begin
                            state_q <= FETCH_FAULT;
                        end else begin
                            pc_q    <= redirect_pc;
                            state_q <= FETCH_RUN;
                        end
`else
                        pc_q    <= redirect_pc;
                        state_q <= FETCH_RUN;
`endif
                    end else if (!stall && state_q == FETCH_RUN) begin
                        count_q <= count_q + 32'd1;
                        // The halt word is captured and counted, but the PC parks on it.
                        if (im_dout == HALT_WORD) state_q <= FETCH_HALT;
                        else                      pc_q    <= pc_plus4;
                    end
                end
                default: ;
            endcase
        end
    end

    if_id_reg u_if_id (
        .clk     (clk),
        .rst_n   (rst_n),
        .hold_i  (ifid_hold),
        .clear_i (ifid_clear),
        .instr_i (im_dout),
        .pc4_i   (pc_plus4),
        .instr_o (ifid_instr),
        .pc4_o   (ifid_pc4),
        .valid_o (ifid_valid)
    );

    assign pc          = pc_q;
    assign im_addr     = pc_q[11:2];
    assign fetch_count = count_q;
    assign halted      = (state_q == FETCH_HALT);
`ifdef IM_FAULT_EN
    assign fault       = (state_q == FETCH_FAULT);
`else
    assign fault       = 1'b0;
`endif

endmodule

// File: tb/tb_im_fetch_ctrl.sv
// Self-checking bench for im_fetch_ctrl: behavioural fetch model compared every cycle,
// plus directed literal expectations. Build with +define+IM_FAULT_EN for the fault variant.
module tb_im_fetch_ctrl;

    localparam logic [31:0] RST_PC = 32'h0000_3000;
    localparam logic [31:0] HALT_W = 32'h0000_000C;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic [9:0]  im_addr;
    logic [31:0] im_dout;
    logic [31:0] pc;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc4;
    logic        ifid_valid;
    logic        halted;
    logic        fault;
    logic [31:0] fetch_count;

    logic [31:0] mem [1024];
    int checks = 0;
    int failures = 0;

    assign im_dout = mem[im_addr];
    always #5 clk = ~clk;

    im_fetch_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .im_addr     (im_addr),
        .im_dout     (im_dout),
        .pc          (pc),
        .ifid_instr  (ifid_instr),
        .ifid_pc4    (ifid_pc4),
        .ifid_valid  (ifid_valid),
        .halted      (halted),
        .fault       (fault),
        .fetch_count (fetch_count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model of the fetch rules.
    logic [31:0] m_pc, m_instr, m_pc4, m_count;
    bit m_valid, m_boot, m_halted, m_fault, m_live = 1'b0;

    function automatic bit illegal_target(input logic [31:0] t);
`ifdef IM_FAULT_EN
        return (t[1:0] != 2'b00) || (t < RST_PC) || ({1'b0, t} >= ({1'b0, RST_PC} + 33'd4096));
`else
        return (t === 32'hxxxx_xxxx);
`endif
    endfunction

    task automatic model_bubble();
        m_instr = 32'h0;
        m_pc4   = 32'h0;
        m_valid = 1'b0;
    endtask

    always @(posedge clk) begin
        logic [31:0] w;
        if (!rst_n) begin
            m_pc = RST_PC; m_count = 0; m_boot = 1; m_halted = 0; m_fault = 0; m_live = 1;
            model_bubble();
        end else if (m_live) begin
            if (m_boot) begin
                m_boot = 0;
                model_bubble();
            end else if (m_fault) begin
                // frozen until reset
            end else if (redirect) begin
                if (illegal_target(redirect_pc)) m_fault = 1;
                else begin
                    m_pc = redirect_pc;
                    m_halted = 0;
                end
                model_bubble();
            end else if (stall) begin
                // everything holds
            end else if (m_halted) begin
                model_bubble();
            end else begin
                w = mem[m_pc[11:2]];
                m_instr = w;
                m_pc4 = m_pc + 32'd4;
                m_valid = 1;
                m_count = m_count + 32'd1;
                if (w == HALT_W) m_halted = 1;
                else m_pc = m_pc + 32'd4;
            end
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            check("m_pc", pc, m_pc);
            check("m_im_addr", {22'b0, im_addr}, {22'b0, m_pc[11:2]});
            check("m_instr", ifid_instr, m_instr);
            check("m_pc4", ifid_pc4, m_pc4);
            check("m_valid", {31'b0, ifid_valid}, {31'b0, m_valid});
            check("m_halted", {31'b0, halted}, {31'b0, m_halted});
            check("m_fault", {31'b0, fault}, {31'b0, m_fault});
            check("m_count", fetch_count, m_count);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'hA000_0000 | i;
        mem[0] = 32'h11; mem[1] = 32'h22; mem[2] = 32'h33; mem[3] = 32'h44;

        // Reset then free-run
        tick(2);
        check("rst_pc", pc, 32'h3000);
        check("rst_valid", {31'b0, ifid_valid}, 32'd0);
        check("rst_count", fetch_count, 32'd0);
        rst_n = 1'b1;
        tick(1);
        check("boot_valid", {31'b0, ifid_valid}, 32'd0);
        tick(1);
        check("run_instr0", ifid_instr, 32'h11);
        check("run_pc0", pc, 32'h3004);
        check("run_pc4_0", ifid_pc4, 32'h3004);
        check("run_count0", fetch_count, 32'd1);
        tick(1);
        check("run_instr1", ifid_instr, 32'h22);
        check("run_pc1", pc, 32'h3008);

        // Stall for three cycles at pc=0x3008
        stall = 1'b1;
        tick(3);
        check("stall_pc", pc, 32'h3008);
        check("stall_instr", ifid_instr, 32'h22);
        check("stall_count", fetch_count, 32'd2);
        stall = 1'b0;
        tick(1);
        check("unstall_instr", ifid_instr, 32'h33);
        check("unstall_count", fetch_count, 32'd3);

        // Redirect wins over stall, one bubble, then word 16
        redirect = 1'b1; stall = 1'b1; redirect_pc = 32'h3040;
        tick(1);
        check("redir_pc", pc, 32'h3040);
        check("redir_bubble", {31'b0, ifid_valid}, 32'd0);
        redirect = 1'b0; stall = 1'b0;
        tick(1);
        check("redir_instr", ifid_instr, 32'hA000_0010);
        check("redir_pc4", ifid_pc4, 32'h3044);

        // Halt word at word 2
        mem[2] = HALT_W;
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        tick(4);
        check("halt_flag", {31'b0, halted}, 32'd1);
        check("halt_instr", ifid_instr, HALT_W);
        check("halt_valid", {31'b0, ifid_valid}, 32'd1);
        check("halt_pc", pc, 32'h3008);
        check("halt_count", fetch_count, 32'd3);
        tick(1);
        check("halt_bubble", {31'b0, ifid_valid}, 32'd0);
        check("halt_pc_hold", pc, 32'h3008);
        redirect = 1'b1; redirect_pc = 32'h3000;
        tick(1);
        check("unhalt_flag", {31'b0, halted}, 32'd0);
        check("unhalt_pc", pc, 32'h3000);
        redirect = 1'b0;
        tick(1);
        check("restart_instr", ifid_instr, 32'h11);
        tick(2);
        check("rehalt_flag", {31'b0, halted}, 32'd1);

        // Reset in HALT while stalled
        stall = 1'b1; rst_n = 1'b0;
        tick(1);
        check("hrst_pc", pc, 32'h3000);
        check("hrst_halted", {31'b0, halted}, 32'd0);
        check("hrst_instr", ifid_instr, 32'h0);
        check("hrst_count", fetch_count, 32'd0);
        stall = 1'b0; rst_n = 1'b1;
        tick(1);
        check("hrst_boot", {31'b0, ifid_valid}, 32'd0);

        // Address wrap at word 1023
        redirect = 1'b1; redirect_pc = 32'h3FFC;
        tick(1);
        check("wrap_addr_hi", {22'b0, im_addr}, 32'd1023);
        redirect = 1'b0;
        tick(1);
        check("wrap_addr_lo", {22'b0, im_addr}, 32'd0);
        check("wrap_pc", pc, 32'h4000);
        check("wrap_instr", ifid_instr, 32'hA000_03FF);

        // Misaligned redirect
        redirect = 1'b1; redirect_pc = 32'h3002;
        tick(1);
        redirect = 1'b0;
`ifdef IM_FAULT_EN
        check("fault_set", {31'b0, fault}, 32'd1);
        check("fault_pc", pc, 32'h4000);
        tick(3);
        check("fault_valid", {31'b0, ifid_valid}, 32'd0);
        check("fault_sticky", {31'b0, fault}, 32'd1);
`else
        check("nofault_flag", {31'b0, fault}, 32'd0);
        check("nofault_addr", {22'b0, im_addr}, 32'd0);
        tick(1);
        check("nofault_instr", ifid_instr, 32'h11);
`endif
        rst_n = 1'b0;
        tick(1);
        check("final_fault", {31'b0, fault}, 32'd0);
        check("final_pc", pc, 32'h3000);
        rst_n = 1'b1;
        tick(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
